// File: rtl/uart_led_frame_rx_if.sv
// Host-facing UART line plus the colour/handshake bus to the WS2812 driver.
// The master modport is the receiver side; the slave modport is the driver/host side.
interface uart_led_frame_rx_if;
    logic        i_Rx;
    logic        i_Ready;
    logic [23:0] o_Colour;
    logic        o_Start;
    logic        o_Frame_Err;
    logic        o_Overrun;
    logic        o_Busy;

    modport master (input i_Rx, i_Ready,
                    output o_Colour, o_Start, o_Frame_Err, o_Overrun, o_Busy);
    modport slave  (output i_Rx, i_Ready,
                    input o_Colour, o_Start, o_Frame_Err, o_Overrun, o_Busy);
endinterface

// File: rtl/uart_led_frame_rx.sv
// 8N1 UART receiver and sync/G/R/B frame assembler feeding the WS2812 driver.
// Define UART_LED_CHECKSUM_EN to append a G^R^B check byte to every frame.
module uart_led_frame_rx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_BITS = 20
) (
    input  logic i_Clock,
    input  logic i_Reset,
    uart_led_frame_rx_if.master bus
);
    localparam int CW     = $clog2(CLKS_PER_BIT);
    localparam int TO_LIM = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW     = $clog2(TO_LIM + 1);
    localparam logic [CW-1:0] HALF    = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL    = CW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TO_LIM - 1);

    // rx_d keeps the previous synced sample so only a real falling edge opens a byte
    logic rx_s1, rx_s2, rx_d;
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= bus.i_Rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end
    wire rx_fall = rx_d & ~rx_s2;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    rx_state_t     rx_state, rx_next;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shreg, sh_n;
    logic          byte_valid, rx_err;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            rx_state <= R_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            rx_state <= rx_next;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            shreg    <= sh_n;
        end
    end

    always_comb begin
        rx_next    = rx_state;
        cnt_n      = cnt + CW'(1);
        bit_n      = bit_idx;
        sh_n       = shreg;
        byte_valid = 1'b0;
        rx_err     = 1'b0;
        case (rx_state)
            R_IDLE: begin
                cnt_n = '0;
                if (rx_fall) rx_next = R_START;
            end
            R_START: if (cnt == HALF) begin
                cnt_n   = '0;
                bit_n   = '0;
                rx_next = rx_s2 ? R_IDLE : R_DATA;
            end
            R_DATA: if (cnt == FULL) begin
                cnt_n = '0;
                sh_n  = {rx_s2, shreg[7:1]};
                bit_n = bit_idx + 3'd1;
                if (bit_idx == 3'd7) rx_next = R_STOP;
            end
            R_STOP: if (cnt == FULL) begin
                // leave at stop-bit centre so a back-to-back start edge is not missed
                cnt_n      = '0;
                rx_next    = R_IDLE;
                byte_valid = rx_s2;
                rx_err     = ~rx_s2;
            end
            default: rx_next = R_IDLE;
        endcase
    end

`ifdef UART_LED_CHECKSUM_EN
    typedef enum logic [2:0] {A_HUNT, A_G, A_R, A_B, A_CK} asm_state_t;
`else
    typedef enum logic [1:0] {A_HUNT, A_G, A_R, A_B} asm_state_t;
`endif
    asm_state_t    asm_state, asm_next;
    logic [7:0]    g_q, r_q, b_q, g_n, r_n, b_n;
    logic [TW-1:0] timer, timer_n;
    logic [23:0]   colour_q, colour_n;
    logic          start_q, start_n, ferr_q, ferr_n, ovr_q, ovr_n;
    logic          in_frame, timeout, done;

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            asm_state <= A_HUNT;
            g_q       <= '0;
            r_q       <= '0;
            b_q       <= '0;
            timer     <= '0;
            colour_q  <= '0;
            start_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            asm_state <= asm_next;
            g_q       <= g_n;
            r_q       <= r_n;
            b_q       <= b_n;
            timer     <= timer_n;
            colour_q  <= colour_n;
            start_q   <= start_n;
            ferr_q    <= ferr_n;
            ovr_q     <= ovr_n;
        end
    end

    always_comb begin
        asm_next = asm_state;
        g_n      = g_q;
        r_n      = r_q;
        b_n      = b_q;
        colour_n = colour_q;
        start_n  = start_q;
        ferr_n   = rx_err;
        ovr_n    = 1'b0;
        done     = 1'b0;
        in_frame = (asm_state != A_HUNT);
        timer_n  = (byte_valid || !in_frame) ? '0 : timer + TW'(1);
        timeout  = in_frame && !byte_valid && (timer == TO_LAST);
        if (start_q && !bus.i_Ready) start_n = 1'b0;
        if (timeout) begin
            asm_next = A_HUNT;
            ferr_n   = 1'b1;
        end else if (rx_err) begin
            asm_next = A_HUNT;
        end else if (byte_valid) begin
            case (asm_state)
                A_HUNT: if (shreg == SYNC_BYTE) asm_next = A_G;
                A_G: begin g_n = shreg; asm_next = A_R; end
                A_R: begin r_n = shreg; asm_next = A_B; end
`ifdef UART_LED_CHECKSUM_EN
                A_B: begin b_n = shreg; asm_next = A_CK; end
                A_CK: begin
                    asm_next = A_HUNT;
                    if (shreg == (g_q ^ r_q ^ b_q)) done = 1'b1;
                    else ferr_n = 1'b1;
                end
`else
                A_B: begin b_n = shreg; asm_next = A_HUNT; done = 1'b1; end
`endif
                default: asm_next = A_HUNT;
            endcase
        end
        // a completed frame always wins over the driver's acceptance in the same cycle
        if (done) begin
`ifdef UART_LED_CHECKSUM_EN
            colour_n = {g_q, r_q, b_q};
`else
            colour_n = {g_q, r_q, shreg};
`endif
            ovr_n   = start_q;
            start_n = 1'b1;
        end
    end

    assign bus.o_Colour    = colour_q;
    assign bus.o_Start     = start_q;
    assign bus.o_Frame_Err = ferr_q;
    assign bus.o_Overrun   = ovr_q;
    assign bus.o_Busy      = (asm_state != A_HUNT);
endmodule

// File: tb/tb_uart_led_frame_rx.sv
// Directed plus randomized byte streams against a byte-level frame model.
`timescale 1ns/1ps
module tb_uart_led_frame_rx;
    localparam int         CPB  = 32;
    localparam int         TOB  = 20;
    localparam logic [7:0] SYNC = 8'hA5;
`ifdef UART_LED_CHECKSUM_EN
    localparam int NB = 4;
`else
    localparam int NB = 3;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_led_frame_rx_if bus();
    uart_led_frame_rx #(.CLKS_PER_BIT(CPB), .SYNC_BYTE(SYNC), .TIMEOUT_BITS(TOB))
        dut (.i_Clock(clk), .i_Reset(rst), .bus(bus));

    int checks = 0;
    int errors = 0;
    int err_cnt = 0;
    int ovr_cnt = 0;

    // every high cycle is counted, so a stretched pulse shows up as an extra event
    always @(negedge clk) if (!rst) begin
        if (bus.o_Frame_Err === 1'b1) err_cnt++;
        if (bus.o_Overrun === 1'b1) ovr_cnt++;
    end

    int          pos;
    logic [7:0]  frm [0:3];
    logic [23:0] m_colour;
    bit          m_start;
    int          m_err, m_ovr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pos = 0; m_colour = '0; m_start = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ok);
        if (!ok) begin
            m_err++;
            pos = 0;
        end else if (pos == 0) begin
            if (b == SYNC) pos = 1;
        end else begin
            frm[pos-1] = b;
            pos++;
            if (pos == NB + 1) begin
                pos = 0;
                if (NB == 4 && frm[3] != (frm[0] ^ frm[1] ^ frm[2])) m_err++;
                else begin
                    if (m_start) m_ovr++;
                    m_colour = {frm[0], frm[1], frm[2]};
                    m_start = 1'b1;
                end
            end
        end
    endtask

    task automatic bit_time(input logic v);
        bus.i_Rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic gap(input int bits);
        bus.i_Rx = 1'b1;
        repeat (bits * CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit ok);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(ok);
        if (!ok) bit_time(1'b1);
        model_byte(b, ok);
    endtask

    task automatic send_frame(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b, input bit ck_ok);
        logic [7:0] ck;
        ck = g ^ r ^ b ^ {7'd0, ~ck_ok};
        send_byte(SYNC, 1'b1);
        send_byte(g, 1'b1);
        send_byte(r, 1'b1);
        send_byte(b, 1'b1);
        if (NB == 4) send_byte(ck, 1'b1);
    endtask

    task automatic check_state(input string tag);
        check({tag, ".colour"}, {8'd0, bus.o_Colour}, {8'd0, m_colour});
        check({tag, ".start"}, {31'd0, bus.o_Start}, {31'd0, m_start});
        check({tag, ".ferr_cnt"}, err_cnt, m_err);
        check({tag, ".ovr_cnt"}, ovr_cnt, m_ovr);
        check({tag, ".busy"}, {31'd0, bus.o_Busy}, {31'd0, pos != 0});
    endtask

    task automatic accept(input string tag);
        bus.i_Ready = 1'b0;
        @(negedge clk);
        m_start = 1'b0;
        check({tag, ".accept"}, {31'd0, bus.o_Start}, 32'd0);
        bus.i_Ready = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        bus.i_Rx = 1'b1;
        bus.i_Ready = 1'b1;
        m_err = 0; m_ovr = 0;
        model_reset();
        repeat (5) @(negedge clk);
        check("rst.colour", {8'd0, bus.o_Colour}, 32'd0);
        check("rst.start", {31'd0, bus.o_Start}, 32'd0);
        check("rst.ferr", {31'd0, bus.o_Frame_Err}, 32'd0);
        check("rst.ovr", {31'd0, bus.o_Overrun}, 32'd0);
        check("rst.busy", {31'd0, bus.o_Busy}, 32'd0);
        rst = 1'b0;
        gap(2);

        send_frame(8'h12, 8'h34, 8'h56, 1'b1);
        check_state("basic");
        check("basic.value", {8'd0, bus.o_Colour}, 32'h123456);
        accept("basic");

        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        for (int i = 0; i < NB + 1; i++) send_byte(8'hA5, 1'b1);
        check_state("syncdata");
        check("syncdata.value", {8'd0, bus.o_Colour}, 32'hA5A5A5);
        accept("syncdata");

        send_byte(SYNC, 1'b1);
        send_byte(8'h11, 1'b0);
        check_state("badstop");
        send_frame(8'h01, 8'h02, 8'h03, 1'b1);
        check_state("afterbad");
        check("afterbad.value", {8'd0, bus.o_Colour}, 32'h010203);
        accept("afterbad");

        send_byte(SYNC, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        gap(TOB - 1);
        check_state("timeout.before");
        gap(2);
        m_err++; pos = 0;
        check_state("timeout.after");

        send_frame(8'h01, 8'h02, 8'h03, 1'b1);
        gap(1);
        send_frame(8'h0A, 8'h0B, 8'h0C, 1'b1);
        check_state("overrun");
        check("overrun.value", {8'd0, bus.o_Colour}, 32'h0A0B0C);
        accept("overrun");

        send_byte(SYNC, 1'b1);
        bus.i_Rx = 1'b0;
        repeat (10) @(negedge clk);
        gap(2);
        check_state("glitch");
        send_byte(8'h07, 1'b1);
        send_byte(8'h08, 1'b1);
        send_byte(8'h09, 1'b1);
        if (NB == 4) send_byte(8'h07 ^ 8'h08 ^ 8'h09, 1'b1);
        check_state("glitch.frame");
        accept("glitch");

        send_frame(8'h21, 8'h43, 8'h65, 1'b1);
        send_byte(SYNC, 1'b1);
        send_byte(8'h11, 1'b1);
        bus.i_Rx = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        bus.i_Rx = 1'b1;
        rst = 1'b0;
        model_reset();
        gap(2);
        check_state("midreset");
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        send_byte(8'h44, 1'b1);
        if (NB == 4) send_byte(8'h55, 1'b1);
        check_state("midreset.nosync");
        send_frame(8'h55, 8'h66, 8'h77, 1'b1);
        check_state("midreset.frame");
        accept("midreset");

        if (NB == 4) begin
            send_frame(8'h12, 8'h34, 8'h56, 1'b0);
            check_state("ckbad");
        end

        for (int it = 0; it < 10; it++) begin
            int junk;
            junk = $urandom_range(0, 2);
            for (int j = 0; j < junk; j++) begin
                v = 8'($urandom);
                send_byte(v, 1'b1);
            end
            send_byte(SYNC, 1'b1);
            for (int j = 0; j < NB; j++) begin
                gap($urandom_range(0, 2));
                v = 8'($urandom);
                if (NB == 4 && j == 3 && $urandom_range(0, 3) != 0) v = frm[0] ^ frm[1] ^ frm[2];
                send_byte(v, $urandom_range(0, 7) != 0);
            end
            check_state($sformatf("rand%0d", it));
            if ($urandom_range(0, 1) == 1) accept($sformatf("rand%0d", it));
        end

        gap(2);
        check_state("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
